mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/rv32_mem_pkg.sv | 19 +
 rtl/mem_arb_priority.sv | 34 +++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared types for the single-port memory arbiter: data width, requester
// identity and arbiter FSM state.
package rv32_mem_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2,
        OWN_STORE = 2'd3
    } owner_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_arb_priority.sv
// Combinational winner selection: store > load > fetch, unless fetch has lost
// STARVE_LIMIT arbitrations in a row, in which case fetch wins outright.
module mem_arb_priority
    import rv32_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             fetch_req_i,
    input  logic             load_req_i,
    input  logic             store_req_i,
    input  logic [CNT_W-1:0] starve_cnt_i,
    output owner_e           winner_o
);

    logic starved;

    assign starved = (starve_cnt_i >= CNT_W'(STARVE_LIMIT));

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise an uncovered path infers a latch.
        winner_o = OWN_NONE;
        if (fetch_req_i && starved) begin
            winner_o = OWN_FETCH;
        end else if (store_req_i) begin
            winner_o = OWN_STORE;
        end else if (load_req_i) begin
            winner_o = OWN_LOAD;
        end else if (fetch_req_i) begin
            winner_o = OWN_FETCH;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch, load and store requesters: one access
// in flight, combinational one-cycle grant, registered completion strobes.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = rv32_mem_pkg::XLEN
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            fetch_req,
    input  logic [XLEN-1:0] fetch_addr,
    output logic            fetch_grant,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_data,

    input  logic            load_req,
    input  logic [XLEN-1:0] load_addr,
    output logic            load_grant,
    output logic            load_valid,
    output logic [XLEN-1:0] load_data,

    input  logic            store_req,
    input  logic [XLEN-1:0] store_addr,
    input  logic [XLEN-1:0] store_data,
    output logic            store_grant,
    output logic            store_done,

    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,

    output logic            busy
);

    import rv32_mem_pkg::*;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e       state_q, state_d;
    owner_e           owner_q;
    owner_e           winner;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             mem_we_q;
    logic [XLEN-1:0]  mem_addr_q, mem_wdata_q;
    logic             fetch_valid_q, load_valid_q, store_done_q;
    logic [XLEN-1:0]  fetch_data_q, load_data_q;
    logic             arbitrate, complete;

    mem_arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_priority (
        .fetch_req_i  (fetch_req),
        .load_req_i   (load_req),
        .store_req_i  (store_req),
        .starve_cnt_i (starve_cnt_q),
        .winner_o     (winner)
    );

    assign arbitrate = (state_q == IDLE) && (winner != OWN_NONE);
    assign complete  = (state_q == ACCESS) && mem_ack;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arbitrate) state_d = ACCESS;
            ACCESS:  if (mem_ack)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_grant = 1'b0;
        load_grant  = 1'b0;
        store_grant = 1'b0;
        if (reset && state_q == IDLE) begin
            fetch_grant = (winner == OWN_FETCH);
            load_grant  = (winner == OWN_LOAD);
            store_grant = (winner == OWN_STORE);
        end
        mem_req = (state_q == ACCESS);
        busy    = mem_req | fetch_valid_q | load_valid_q | store_done_q;
    end

    // A lost arbitration only counts while fetch is actually asking.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == IDLE) begin
            if (!fetch_req || winner == OWN_FETCH) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            owner_q       <= OWN_NONE;
            starve_cnt_q  <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            fetch_valid_q <= 1'b0;
            load_valid_q  <= 1'b0;
            store_done_q  <= 1'b0;
            fetch_data_q  <= '0;
            load_data_q   <= '0;
        end else begin
            starve_cnt_q  <= starve_cnt_d;
            fetch_valid_q <= complete && (owner_q == OWN_FETCH);
            load_valid_q  <= complete && (owner_q == OWN_LOAD);
            store_done_q  <= complete && (owner_q == OWN_STORE);

            if (arbitrate) begin
                owner_q  <= winner;
                mem_we_q <= (winner == OWN_STORE);
                case (winner)
                    OWN_FETCH: mem_addr_q <= fetch_addr;
                    OWN_LOAD:  mem_addr_q <= load_addr;
                    OWN_STORE: begin
                        mem_addr_q  <= store_addr;
                        mem_wdata_q <= store_data;
                    end
                    default: ;
                endcase
            end

            if (complete) begin
                owner_q  <= OWN_NONE;
                mem_we_q <= 1'b0;
                if (owner_q == OWN_FETCH) fetch_data_q <= mem_rdata;
                if (owner_q == OWN_LOAD)  load_data_q  <= mem_rdata;
            end
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign fetch_valid = fetch_valid_q;
    assign load_valid  = load_valid_q;
    assign store_done  = store_done_q;
    assign fetch_data  = fetch_data_q;
    assign load_data   = load_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single fetch, contention, starvation,
// wait states, reset mid-access and a stray ack, all with hand-derived values.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            fetch_req, load_req, store_req;
    logic [XLEN-1:0] fetch_addr, load_addr, store_addr, store_data;
    logic            fetch_grant, fetch_valid, load_grant, load_valid;
    logic            store_grant, store_done;
    logic [XLEN-1:0] fetch_data, load_data;
    logic            mem_req, mem_we, mem_ack, busy;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .STARVE_LIMIT (4),
        .XLEN         (XLEN)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_grant (fetch_grant),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .load_req    (load_req),
        .load_addr   (load_addr),
        .load_grant  (load_grant),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .store_req   (store_req),
        .store_addr  (store_addr),
        .store_data  (store_data),
        .store_grant (store_grant),
        .store_done  (store_done),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: returns 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // {fetch_grant, load_grant, store_grant}
    function automatic logic [2:0] grants();
        return {fetch_grant, load_grant, store_grant};
    endfunction

    // Every strobe/control output that must be 0 when nothing is happening.
    function automatic logic [8:0] strobes();
        return {fetch_grant, load_grant, store_grant, fetch_valid, load_valid,
                store_done, mem_req, mem_we, busy};
    endfunction

    initial begin
        reset      = 1'b0;
        fetch_req  = 1'b0; fetch_addr = '0;
        load_req   = 1'b0; load_addr  = '0;
        store_req  = 1'b0; store_addr = '0; store_data = '0;
        mem_ack    = 1'b0; mem_rdata  = '0;

        // Reset state
        tick(); tick();
        check("reset_strobes", 32'(strobes()), 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_wdata", mem_wdata, 32'h0);
        check("reset_fetch_data", fetch_data, 32'h0);
        check("reset_load_data", load_data, 32'h0);
        reset = 1'b1;
        tick();

        // Single fetch against a registered memory: ack one cycle after it sees mem_req.
        fetch_req = 1'b1; fetch_addr = 32'h0000_0100;
        #1;
        check("f1_grant_t", 32'(grants()), 32'h4);
        check("f1_memreq_t", 32'(mem_req), 32'h0);
        tick();
        fetch_req = 1'b0;
        #1;
        check("f1_memreq_t1", 32'(mem_req), 32'h1);
        check("f1_addr_t1", mem_addr, 32'h0000_0100);
        check("f1_we_t1", 32'(mem_we), 32'h0);
        check("f1_busy_t1", 32'(busy), 32'h1);
        check("f1_grant_t1", 32'(grants()), 32'h0);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        #1;
        check("f1_memreq_t2", 32'(mem_req), 32'h1);
        check("f1_valid_t2", 32'(fetch_valid), 32'h0);
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        check("f1_valid_t3", 32'(fetch_valid), 32'h1);
        check("f1_data_t3", fetch_data, 32'h0050_0093);
        check("f1_memreq_t3", 32'(mem_req), 32'h0);
        check("f1_busy_t3", 32'(busy), 32'h1);
        tick();
        check("f1_quiet_t4", 32'(strobes()), 32'h0);
        check("f1_data_hold", fetch_data, 32'h0050_0093);

        // Contention: all three at once -> store, load, fetch.
        fetch_req = 1'b1; fetch_addr = 32'h0000_0104;
        load_req  = 1'b1; load_addr  = 32'h0000_1000;
        store_req = 1'b1; store_addr = 32'h0000_1004; store_data = 32'hCAFE_F00D;
        #1;
        check("c_grant_store", 32'(grants()), 32'h1);
        tick();
        store_req = 1'b0;
        mem_ack = 1'b1;
        #1;
        check("c_st_we", 32'(mem_we), 32'h1);
        check("c_st_addr", mem_addr, 32'h0000_1004);
        check("c_st_wdata", mem_wdata, 32'hCAFE_F00D);
        check("c_ignore_req_in_access", 32'(grants()), 32'h0);
        tick();
        mem_ack = 1'b0;
        #1;
        check("c_store_done", 32'(store_done), 32'h1);
        check("c_grant_load", 32'(grants()), 32'h2);
        check("c_dead_cycle", 32'(mem_req), 32'h0);
        tick();
        load_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
        #1;
        check("c_ld_we", 32'(mem_we), 32'h0);
        check("c_ld_addr", mem_addr, 32'h0000_1000);
        check("c_store_done_once", 32'(store_done), 32'h0);
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        check("c_load_valid", 32'(load_valid), 32'h1);
        check("c_load_data", load_data, 32'h1122_3344);
        check("c_grant_fetch", 32'(grants()), 32'h4);
        tick();
        fetch_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h5566_7788;
        #1;
        check("c_f_addr", mem_addr, 32'h0000_0104);
        check("c_f_we", 32'(mem_we), 32'h0);
        check("c_load_valid_once", 32'(load_valid), 32'h0);
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        check("c_fetch_valid", 32'(fetch_valid), 32'h1);
        check("c_fetch_data", fetch_data, 32'h5566_7788);
        check("c_no_other_pulse", 32'({load_valid, store_done}), 32'h0);
        tick();
        check("c_quiet", 32'(strobes()), 32'h0);

        // Starvation: fetch loses four times to a persistent store, wins the fifth.
        fetch_req = 1'b1; fetch_addr = 32'h0000_0200;
        store_req = 1'b1; store_addr = 32'h0000_3000; store_data = 32'hA5A5_0000;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("s_arb%0d_store", i + 1), 32'(grants()), 32'h1);
            tick();
            mem_ack = 1'b1;
            #1;
            check($sformatf("s_arb%0d_we", i + 1), 32'(mem_we), 32'h1);
            tick();
            mem_ack = 1'b0;
        end
        #1;
        check("s_arb5_fetch", 32'(grants()), 32'h4);
        tick();
        fetch_req = 1'b0; store_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        #1;
        check("s_f_we", 32'(mem_we), 32'h0);
        check("s_f_addr", mem_addr, 32'h0000_0200);
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        check("s_fetch_valid", 32'(fetch_valid), 32'h1);
        check("s_fetch_data", fetch_data, 32'h0BAD_F00D);
        tick();

        // Wait states: load to 0x2000, ack on the fourth mem_req cycle.
        load_req = 1'b1; load_addr = 32'h0000_2000;
        #1;
        check("w_grant", 32'(grants()), 32'h2);
        tick();
        load_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
            end
            #1;
            check($sformatf("w_memreq_c%0d", k), 32'(mem_req), 32'h1);
            check($sformatf("w_addr_c%0d", k), mem_addr, 32'h0000_2000);
            check($sformatf("w_novalid_c%0d", k), 32'(load_valid), 32'h0);
            tick();
        end
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        check("w_load_valid", 32'(load_valid), 32'h1);
        check("w_load_data", load_data, 32'hDEAD_BEEF);
        check("w_memreq_drop", 32'(mem_req), 32'h0);
        tick();
        check("w_load_valid_once", 32'(load_valid), 32'h0);
        check("w_load_data_hold", load_data, 32'hDEAD_BEEF);

        // Reset in the middle of a store access, then a late ack.
        store_req = 1'b1; store_addr = 32'h0000_4000; store_data = 32'h0000_0001;
        #1;
        check("r_grant", 32'(grants()), 32'h1);
        tick();
        store_req = 1'b0;
        #1;
        check("r_in_access", 32'(mem_req), 32'h1);
        reset = 1'b0;
        tick();
        check("r_strobes", 32'(strobes()), 32'h0);
        check("r_mem_addr", mem_addr, 32'h0);
        check("r_mem_wdata", mem_wdata, 32'h0);
        check("r_fetch_data", fetch_data, 32'h0);
        check("r_load_data", load_data, 32'h0);
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
        #1;
        check("r_late_ack_now", 32'(strobes()), 32'h0);
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        check("r_late_ack_after", 32'(strobes()), 32'h0);
        check("r_late_ack_data", load_data, 32'h0);

        // Stray ack while idle with no requests.
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        check("x_strobes", 32'(strobes()), 32'h0);
        check("x_fetch_data", fetch_data, 32'h0);
        check("x_load_data", load_data, 32'h0);
        check("x_mem_addr", mem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
